// File: rtl/data_conv_pkg.sv
// -----------------------------------------------------------------------------
// data_conv_pkg
// Shared constants and helpers for the 2x32 <-> 128-bit sample packer and
// the matching unpacker (data_deconv).
//
// Contents:
//   WORD_W / SAMPLE_W / LANE_W  : packed word, per-channel sample, 16-bit lane
//   CH0_OFF / CH1_OFF           : bit offset of each channel inside a word
//   SIN_OFF                     : sin lanes sit 32 bits above the cos lanes
//   SLOT_OFF                    : slot 1 lanes sit 16 bits above slot 0
//   state_t                     : unpacker FSM states
//   swap16()                    : byte swap of one 16-bit lane
//   unpack_sample()             : pull one {sin,cos} sample out of a word
// -----------------------------------------------------------------------------
package data_conv_pkg;

  localparam int WORD_W   = 128;
  localparam int SAMPLE_W = 32;
  localparam int LANE_W   = 16;

  localparam logic [6:0] CH0_OFF  = 7'd0;
  localparam logic [6:0] CH1_OFF  = 7'd64;
  localparam logic [6:0] SIN_OFF  = 7'd32;
  localparam logic [6:0] SLOT_OFF = 7'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  // The packer stores each lane big-endian; swapping the bytes restores
  // the little-endian lane the NCO produced.
  function automatic logic [LANE_W-1:0] swap16(input logic [LANE_W-1:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // One channel's sample for a given slot: cos lanes live at
  // ch_off + 16*slot, sin lanes a further 32 bits up.
  function automatic logic [SAMPLE_W-1:0] unpack_sample(
    input logic [WORD_W-1:0] w,
    input logic [6:0]        ch_off,
    input logic              slot
  );
    logic [6:0] base;
    base = ch_off + (slot ? SLOT_OFF : 7'd0);
    return {swap16(w[base + SIN_OFF +: LANE_W]), swap16(w[base +: LANE_W])};
  endfunction

endpackage

// File: rtl/data_deconv_fifo.sv
// -----------------------------------------------------------------------------
// data_deconv_fifo
// Two-entry, first-word-fall-through word buffer in front of the unpacker.
// The head word is always visible on dout while the buffer is non-empty.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   clear  in   synchronous flush; wins over push and pop
//   push   in   write din (ignored when full)
//   pop    in   drop the head word (ignored when empty)
//   din    in   128-bit word to store
//   dout   out  head word
//   full   out  both entries occupied
//   empty  out  no entries occupied
// -----------------------------------------------------------------------------
module data_deconv_fifo
  import data_conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        level;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == 2'd2);
  assign empty   = (level == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; a simultaneous push and pop leaves level alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      level <= level + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: contents are only observed through level.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_deconv.sv
// -----------------------------------------------------------------------------
// data_deconv
// Unpacks 128-bit words holding two {sin,cos} samples for each of two
// channels back into one sample per clock per channel. Words are buffered in
// a 2-entry FIFO; an underrun is flagged when a sample falls due and no word
// is available.
//
// Optional feature: define DATA_DECONV_UNDERRUN_CNT_EN to build a 16-bit
// saturating underrun counter; otherwise underrun_cnt_o is tied to 0.
//
// Ports:
//   clk_i           in   sample clock
//   reset_n_i       in   asynchronous active-low reset
//   en_i            in   stream enable; low flushes and returns to IDLE
//   ch0_en / ch1_en in   channel enables; a disabled channel outputs 0
//   word_i          in   packed 128-bit word
//   word_valid_i    in   word_i valid
//   word_ready_o    out  buffer can accept a word (registered)
//   data0_o/data1_o out  channel samples, [31:16] sin, [15:0] cos
//   sample_valid_o  out  data outputs valid this cycle
//   phase_o         out  slot of the current sample (0 first, 1 second)
//   underrun_o      out  one-cycle pulse after the last sample of a run
//   underrun_cnt_o  out  saturating underrun count
// -----------------------------------------------------------------------------
module data_deconv
  import data_conv_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                en_i,
  input  logic                ch0_en,
  input  logic                ch1_en,
  input  logic [WORD_W-1:0]   word_i,
  input  logic                word_valid_i,
  output logic                word_ready_o,
  output logic [SAMPLE_W-1:0] data0_o,
  output logic [SAMPLE_W-1:0] data1_o,
  output logic                sample_valid_o,
  output logic                phase_o,
  output logic                underrun_o,
  output logic [15:0]         underrun_cnt_o
);

  state_t              state;
  logic                slot;
  logic                ready_q;
  logic                valid_q;
  logic                phase_q;
  logic                underrun_q;
  logic [SAMPLE_W-1:0] data0_q;
  logic [SAMPLE_W-1:0] data1_q;

  logic [WORD_W-1:0]   head;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                next_full;
  logic                emit;
  logic [SAMPLE_W-1:0] sample0;
  logic [SAMPLE_W-1:0] sample1;

  // ready_q is a registered copy of "not full", so it alone gates the push.
  assign push = word_valid_i & ready_q;

  // The head word leaves on the same edge its slot-1 sample is registered.
  assign pop  = en_i & (state == RUN) & slot;

  // A sample goes out when slot 1 is pending or a new head word is present.
  assign emit = en_i & (((state == RUN) & slot) | ~empty);

  // Full after this edge: stays full without a pop, or fills from one entry.
  assign next_full = ~pop & (full | (push & ~empty));

  assign sample0 = ch0_en ? unpack_sample(head, CH0_OFF, slot) : '0;
  assign sample1 = ch1_en ? unpack_sample(head, CH1_OFF, slot) : '0;

  data_deconv_fifo u_fifo (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .clear (~en_i),
    .push  (push),
    .pop   (pop),
    .din   (word_i),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef DATA_DECONV_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;
  assign underrun_cnt_o = ucnt_q;
`else
  assign underrun_cnt_o = 16'd0;
`endif

  // Sequencer: slot holds the next slot to emit. In RUN with slot 0 pending
  // and nothing buffered, the stream has run dry, so it drops to STALL and
  // flags the underrun one cycle after the final slot-1 sample. IDLE and
  // STALL restart identically; only a RUN->STALL transition pulses.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      slot       <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      phase_q    <= 1'b0;
      underrun_q <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
`ifdef DATA_DECONV_UNDERRUN_CNT_EN
      ucnt_q     <= 16'd0;
`endif
    end else begin
      ready_q    <= en_i & ~next_full;
      valid_q    <= 1'b0;
      phase_q    <= 1'b0;
      underrun_q <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;

      if (emit) begin
        valid_q <= 1'b1;
        phase_q <= slot;
        data0_q <= sample0;
        data1_q <= sample1;
      end

      if (!en_i) begin
        state <= IDLE;
        slot  <= 1'b0;
      end else begin
        case (state)
          IDLE, STALL: begin
            if (!empty) begin
              state <= RUN;
              slot  <= 1'b1;
            end
          end
          RUN: begin
            if (slot) begin
              slot <= 1'b0;
            end else if (!empty) begin
              slot <= 1'b1;
            end else begin
              state      <= STALL;
              underrun_q <= 1'b1;
`ifdef DATA_DECONV_UNDERRUN_CNT_EN
              if (ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
`endif
            end
          end
          default: begin
            state <= IDLE;
            slot  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign word_ready_o   = ready_q;
  assign data0_o        = data0_q;
  assign data1_o        = data1_q;
  assign sample_valid_o = valid_q;
  assign phase_o        = phase_q;
  assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_data_deconv.sv
// -----------------------------------------------------------------------------
// tb_data_deconv
// Directed bench for data_deconv. Expected samples are queued as each word is
// offered and compared by a negedge monitor whenever the DUT marks a sample
// valid; timing-specific behaviour is checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_data_deconv;

  logic         clk_i;
  logic         reset_n_i;
  logic         en_i;
  logic         ch0_en;
  logic         ch1_en;
  logic [127:0] word_i;
  logic         word_valid_i;
  logic         word_ready_o;
  logic [31:0]  data0_o;
  logic [31:0]  data1_o;
  logic         sample_valid_o;
  logic         phase_o;
  logic         underrun_o;
  logic [15:0]  underrun_cnt_o;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ph;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [127:0] stream_words [8];

  int pass_cnt     = 0;
  int total_cnt    = 0;
  int fail_cnt     = 0;
  int underrun_seen = 0;
  int run_len      = 0;
  int max_run      = 0;
  int exp_uc       = 0;

  data_deconv dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .en_i           (en_i),
    .ch0_en         (ch0_en),
    .ch1_en         (ch1_en),
    .word_i         (word_i),
    .word_valid_i   (word_valid_i),
    .word_ready_o   (word_ready_o),
    .data0_o        (data0_o),
    .data1_o        (data1_o),
    .sample_valid_o (sample_valid_o),
    .phase_o        (phase_o),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  // Free-running 100 MHz-style clock, period 10.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard stop in case something upstream of every bounded wait goes wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Sample reference built straight from the byte layout of a packed word.
  function automatic logic [31:0] model_sample(input logic [127:0] w, input int k, input int s);
    logic [15:0] c;
    logic [15:0] sn;
    int          b;
    b  = k + 16 * s;
    c  = {w[b +: 8], w[b + 8 +: 8]};
    sn = {w[b + 32 +: 8], w[b + 40 +: 8]};
    return {sn, c};
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef DATA_DECONV_UNDERRUN_CNT_EN
    return 16'(exp_uc);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Offer one word, queue its two expected samples, and return #1 after the
  // edge on which it was accepted.
  task automatic apply_stimulus(input logic [127:0] w);
    exp_t e;
    int   n;
    word_i       = w;
    word_valid_i = 1'b1;
    for (int s = 0; s < 2; s++) begin
      e.d0 = ch0_en ? model_sample(w, 0, s) : 32'd0;
      e.d1 = ch1_en ? model_sample(w, 64, s) : 32'd0;
      e.ph = (s == 1);
      exp_q.push_back(e);
    end
    n = 0;
    while (!word_ready_o && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) check_output("ready_timeout", 32'(word_ready_o), 32'd1);
    tick(1);
    word_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check_output("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every valid sample must match the oldest expected
  // entry; also tracks underrun pulses and the longest unbroken valid run.
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (underrun_o) underrun_seen++;
      if (sample_valid_o) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          check_output("spurious_valid", 32'(sample_valid_o), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("data0", data0_o, mon_e.d0);
          check_output("data1", data1_o, mon_e.d1);
          check_output("phase", 32'(phase_o), 32'(mon_e.ph));
        end
      end else begin
        run_len = 0;
      end
    end
  end

  // Directed sequence.
  initial begin
    logic [127:0] w;

    reset_n_i    = 1'b0;
    en_i         = 1'b0;
    ch0_en       = 1'b1;
    ch1_en       = 1'b1;
    word_i       = '0;
    word_valid_i = 1'b0;

    // Reset values.
    #12;
    check_output("rst_valid", 32'(sample_valid_o), 32'd0);
    check_output("rst_data0", data0_o, 32'd0);
    check_output("rst_data1", data1_o, 32'd0);
    check_output("rst_phase", 32'(phase_o), 32'd0);
    check_output("rst_underrun", 32'(underrun_o), 32'd0);
    check_output("rst_ready", 32'(word_ready_o), 32'd0);
    check_output("rst_cnt", 32'(underrun_cnt_o), 32'd0);

    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    en_i      = 1'b1;
    tick(1);
    check_output("ready_after_en", 32'(word_ready_o), 32'd1);

    // Single word with the reference byte pattern.
    $display("[TB] single word");
    w = {64'h0123_4567_89AB_CDEF, 64'hF0DE_BC9A_7856_3412};
    apply_stimulus(w);
    check_output("lat_not_yet", 32'(sample_valid_o), 32'd0);
    tick(1);
    check_output("s0_valid", 32'(sample_valid_o), 32'd1);
    check_output("s0_phase", 32'(phase_o), 32'd0);
    check_output("s0_data0", data0_o, 32'h9ABC1234);
    tick(1);
    check_output("s1_valid", 32'(sample_valid_o), 32'd1);
    check_output("s1_phase", 32'(phase_o), 32'd1);
    check_output("s1_data0", data0_o, 32'hDEF05678);
    tick(1);
    exp_uc++;
    check_output("stall_underrun", 32'(underrun_o), 32'd1);
    check_output("stall_valid", 32'(sample_valid_o), 32'd0);
    check_output("stall_data0", data0_o, 32'd0);
    check_output("stall_phase", 32'(phase_o), 32'd0);
    check_output("cnt_single", 32'(underrun_cnt_o), 32'(exp_cnt()));
    tick(1);
    check_output("underrun_one_cycle", 32'(underrun_o), 32'd0);

    // Back-to-back stream of eight words.
    $display("[TB] back-to-back stream");
    for (int i = 0; i < 8; i++) stream_words[i] = {$urandom, $urandom, $urandom, $urandom};
    underrun_seen = 0;
    max_run       = 0;
    for (int i = 0; i < 8; i++) apply_stimulus(stream_words[i]);
    wait_drain();
    tick(2);
    exp_uc++;
    check_output("stream_run", 32'(max_run), 32'd16);
    check_output("stream_underruns", 32'(underrun_seen), 32'd1);
    check_output("cnt_stream", 32'(underrun_cnt_o), 32'(exp_cnt()));

    // Same stream with channel 1 disabled.
    $display("[TB] channel 1 disabled");
    ch1_en        = 1'b0;
    underrun_seen = 0;
    max_run       = 0;
    for (int i = 0; i < 8; i++) apply_stimulus(stream_words[i]);
    wait_drain();
    tick(2);
    exp_uc++;
    check_output("ch1off_run", 32'(max_run), 32'd16);
    check_output("ch1off_underruns", 32'(underrun_seen), 32'd1);
    ch1_en = 1'b1;

    // Source gaps of three cycles: one underrun per gap.
    $display("[TB] gapped source");
    underrun_seen = 0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus({$urandom, $urandom, $urandom, $urandom});
      tick(3);
    end
    wait_drain();
    tick(2);
    exp_uc += 3;
    check_output("gap_underruns", 32'(underrun_seen), 32'd3);
    check_output("cnt_gaps", 32'(underrun_cnt_o), 32'(exp_cnt()));

    // Enable dropped after slot 0: slot 1 is discarded, no underrun.
    $display("[TB] enable drop mid-word");
    underrun_seen = 0;
    apply_stimulus({$urandom, $urandom, $urandom, $urandom});
    tick(1);
    check_output("drop_slot0_valid", 32'(sample_valid_o), 32'd1);
    en_i = 1'b0;
    void'(exp_q.pop_back());
    tick(1);
    check_output("drop_valid", 32'(sample_valid_o), 32'd0);
    check_output("drop_underrun", 32'(underrun_o), 32'd0);
    check_output("drop_ready", 32'(word_ready_o), 32'd0);
    check_output("drop_data0", data0_o, 32'd0);
    en_i = 1'b1;
    tick(4);
    check_output("drop_no_pulse", 32'(underrun_seen), 32'd0);
    check_output("drop_cnt", 32'(underrun_cnt_o), 32'(exp_cnt()));
    check_output("drop_fifo_empty_ready", 32'(word_ready_o), 32'd1);
    check_output("drop_still_idle", 32'(sample_valid_o), 32'd0);

    // Asynchronous reset in the middle of a stream.
    $display("[TB] reset mid-stream");
    apply_stimulus({32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888});
    apply_stimulus({$urandom, $urandom, $urandom, $urandom});
    check_output("pre_reset_valid", 32'(sample_valid_o), 32'd1);
    #3;
    reset_n_i = 1'b0;
    #1;
    exp_q.delete();
    exp_uc = 0;
    check_output("arst_valid", 32'(sample_valid_o), 32'd0);
    check_output("arst_data0", data0_o, 32'd0);
    check_output("arst_data1", data1_o, 32'd0);
    check_output("arst_ready", 32'(word_ready_o), 32'd0);
    check_output("arst_cnt", 32'(underrun_cnt_o), 32'd0);
    tick(2);
    reset_n_i = 1'b1;
    tick(1);
    w = {$urandom, $urandom, $urandom, $urandom};
    apply_stimulus(w);
    check_output("post_rst_not_yet", 32'(sample_valid_o), 32'd0);
    tick(1);
    check_output("post_rst_valid", 32'(sample_valid_o), 32'd1);
    check_output("post_rst_data0", data0_o, model_sample(w, 0, 0));
    wait_drain();
    tick(2);
    exp_uc++;
    check_output("cnt_post_rst", 32'(underrun_cnt_o), 32'(exp_cnt()));

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
